pwm_update_sched: RTL and testbench

PWM_UPDATE_SCHED -- requirements
Module: pwm_update_sched

---
 rtl/pwm_update_sched.sv | 142 ++++++++++++++
 tb/tb_pwm_update_sched.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_update_sched.sv
// PWM configuration scheduler: gates run/stop of the PWM core and applies new
// period/init/compare sets either at once (while idle) or at the next carrier event.
module pwm_update_sched #(
    parameter logic [15:0] DEF_PERIOD = 16'd2000,
    parameter logic [15:0] DEF_INIT   = 16'd500,
    parameter logic [15:0] DEF_CMP    = 16'd1000,
    parameter bit          UPD_ON_MAX = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cfg_valid,
    output logic        cfg_ready,
    input  logic [15:0] cfg_period,
    input  logic [15:0] cfg_init_carr,
    input  logic [15:0] cfg_compare,
    input  logic        start_req,
    input  logic        stop_req,
    input  logic        evt_zero,
    input  logic        evt_max,
    output logic [15:0] period,
    output logic [15:0] init_carr,
    output logic [15:0] compare,
    output logic        pwm_onoff,
    output logic        upd_done,
    output logic        cfg_err,
    output logic [2:0]  state
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ARM  = 3'd1,
        S_RUN  = 3'd2,
        S_PEND = 3'd3,
        S_STOP = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] period_q, period_d, init_q, init_d, cmp_q, cmp_d;
    logic [15:0] sh_period_q, sh_period_d, sh_init_q, sh_init_d, sh_cmp_q, sh_cmp_d;
    logic        onoff_q, onoff_d, upd_done_q, upd_done_d, cfg_err_q, cfg_err_d;

    logic        cfg_acc, cfg_ok, qual_evt;
    logic [15:0] clamp_init, clamp_cmp;

    assign cfg_ready  = !reset && (state_q == S_IDLE || state_q == S_ARM || state_q == S_RUN);
    assign cfg_acc    = cfg_valid && cfg_ready;
    assign cfg_ok     = cfg_period >= 16'd2;
    // Simultaneous evt_zero/evt_max collapse into one event by the OR.
    assign qual_evt   = evt_zero || (UPD_ON_MAX && evt_max);
    assign clamp_init = (cfg_init_carr > cfg_period) ? cfg_period : cfg_init_carr;
    assign clamp_cmp  = (cfg_compare > cfg_period) ? cfg_period : cfg_compare;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            period_q    <= DEF_PERIOD;
            init_q      <= DEF_INIT;
            cmp_q       <= DEF_CMP;
            sh_period_q <= '0;
            sh_init_q   <= '0;
            sh_cmp_q    <= '0;
            onoff_q     <= 1'b0;
            upd_done_q  <= 1'b0;
            cfg_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            period_q    <= period_d;
            init_q      <= init_d;
            cmp_q       <= cmp_d;
            sh_period_q <= sh_period_d;
            sh_init_q   <= sh_init_d;
            sh_cmp_q    <= sh_cmp_d;
            onoff_q     <= onoff_d;
            upd_done_q  <= upd_done_d;
            cfg_err_q   <= cfg_err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (start_req && !stop_req) state_d = S_ARM;
            S_ARM: begin
                if (stop_req)      state_d = S_IDLE;
                else if (evt_zero) state_d = S_RUN;
            end
            S_RUN: begin
                if (stop_req)               state_d = S_STOP;
                else if (cfg_acc && cfg_ok) state_d = S_PEND;
            end
            S_PEND: begin
                if (stop_req)      state_d = S_STOP;
                else if (qual_evt) state_d = S_RUN;
            end
            S_STOP: if (evt_zero) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        period_d    = period_q;
        init_d      = init_q;
        cmp_d       = cmp_q;
        sh_period_d = sh_period_q;
        sh_init_d   = sh_init_q;
        sh_cmp_d    = sh_cmp_q;
        upd_done_d  = 1'b0;
        cfg_err_d   = cfg_acc && !cfg_ok;
        onoff_d     = (state_d == S_RUN || state_d == S_PEND || state_d == S_STOP);

        if (cfg_acc && cfg_ok) begin
            if (state_q == S_IDLE || state_q == S_ARM) begin
                period_d   = cfg_period;
                init_d     = clamp_init;
                cmp_d      = clamp_cmp;
                upd_done_d = 1'b1;
            end else if (state_q == S_RUN && !stop_req) begin
                // A stop in the same cycle wins; the offered set is dropped.
                sh_period_d = cfg_period;
                sh_init_d   = clamp_init;
                sh_cmp_d    = clamp_cmp;
            end
        end

        // Pending set lands on the event even when a stop coincides.
        if (state_q == S_PEND && qual_evt) begin
            period_d   = sh_period_q;
            init_d     = sh_init_q;
            cmp_d      = sh_cmp_q;
            upd_done_d = 1'b1;
        end
    end

    assign period    = period_q;
    assign init_carr = init_q;
    assign compare   = cmp_q;
    assign pwm_onoff = onoff_q;
    assign upd_done  = upd_done_q;
    assign cfg_err   = cfg_err_q;
    assign state     = state_q;

endmodule

// File: tb/tb_pwm_update_sched.sv
// Bench for pwm_update_sched: two instances (update on zero only / zero or max)
// checked every cycle against a spec-level model, plus directed literal checks.
module tb_pwm_update_sched;
    logic clk = 1'b0, reset = 1'b1, cfg_valid = 1'b0;
    logic start_req = 1'b0, stop_req = 1'b0, evt_zero = 1'b0, evt_max = 1'b0;
    logic [15:0] cfg_period = '0, cfg_init_carr = '0, cfg_compare = '0;

    logic        rdy0, rdy1, on0, on1, upd0, upd1, err0, err1;
    logic [15:0] per0, ini0, cmp0, per1, ini1, cmp1;
    logic [2:0]  st0, st1;

    int checks = 0, errors = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    pwm_update_sched #(.UPD_ON_MAX(1'b0)) u0 (
        .clk(clk), .reset(reset), .cfg_valid(cfg_valid), .cfg_ready(rdy0),
        .cfg_period(cfg_period), .cfg_init_carr(cfg_init_carr), .cfg_compare(cfg_compare),
        .start_req(start_req), .stop_req(stop_req), .evt_zero(evt_zero), .evt_max(evt_max),
        .period(per0), .init_carr(ini0), .compare(cmp0), .pwm_onoff(on0),
        .upd_done(upd0), .cfg_err(err0), .state(st0));

    pwm_update_sched #(.UPD_ON_MAX(1'b1)) u1 (
        .clk(clk), .reset(reset), .cfg_valid(cfg_valid), .cfg_ready(rdy1),
        .cfg_period(cfg_period), .cfg_init_carr(cfg_init_carr), .cfg_compare(cfg_compare),
        .start_req(start_req), .stop_req(stop_req), .evt_zero(evt_zero), .evt_max(evt_max),
        .period(per1), .init_carr(ini1), .compare(cmp1), .pwm_onoff(on1),
        .upd_done(upd1), .cfg_err(err1), .state(st1));

    // Model: mode 0..4 = idle/arm/run/pending/stopping, plus the active and pending sets.
    typedef struct {
        int          st;
        bit          on, upd, err;
        logic [15:0] per, ini, cmp, sp, si, sc;
    } mdl_t;

    mdl_t m0, m1;

    function automatic mdl_t mreset();
        mdl_t r;
        r.st = 0; r.on = 0; r.upd = 0; r.err = 0;
        r.per = 16'd2000; r.ini = 16'd500; r.cmp = 16'd1000;
        r.sp = 0; r.si = 0; r.sc = 0;
        return r;
    endfunction

    function automatic mdl_t mstep(input mdl_t m, input bit umax);
        mdl_t n = m;
        bit acc = cfg_valid && (m.st <= 2);
        bit good = cfg_period >= 2;
        bit ev = evt_zero || (umax && evt_max);
        logic [15:0] ci = (cfg_init_carr > cfg_period) ? cfg_period : cfg_init_carr;
        logic [15:0] cc = (cfg_compare > cfg_period) ? cfg_period : cfg_compare;
        if (reset) return mreset();
        n.upd = 0;
        n.err = acc && !good;
        case (m.st)
            0, 1: begin
                if (acc && good) begin
                    n.per = cfg_period; n.ini = ci; n.cmp = cc; n.upd = 1;
                end
                if (m.st == 0 && start_req && !stop_req) n.st = 1;
                if (m.st == 1) n.st = stop_req ? 0 : (evt_zero ? 2 : 1);
            end
            2: begin
                if (stop_req) n.st = 4;
                else if (acc && good) begin
                    n.sp = cfg_period; n.si = ci; n.sc = cc; n.st = 3;
                end
            end
            3: begin
                if (ev) begin
                    n.per = m.sp; n.ini = m.si; n.cmp = m.sc; n.upd = 1;
                end
                n.st = stop_req ? 4 : (ev ? 2 : 3);
            end
            default: if (evt_zero) n.st = 0;
        endcase
        n.on = (n.st >= 2);
        return n;
    endfunction

    always @(posedge clk) begin
        m0 = mstep(m0, 1'b0);
        m1 = mstep(m1, 1'b1);
    end

    task automatic cmp_dut(input string nm, input mdl_t m, input logic [2:0] st, input logic on,
                           input logic upd, input logic err, input logic rdy,
                           input logic [15:0] per, input logic [15:0] ini, input logic [15:0] cmp);
        logic [54:0] got, exp;
        got = {st, on, upd, err, rdy, per, ini, cmp};
        exp = {m.st[2:0], m.on, m.upd, m.err, (!reset && m.st <= 2), m.per, m.ini, m.cmp};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s t=%0t got st/on/upd/err/rdy/per/ini/cmp=%h required %h", nm, $time, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            cmp_dut("model_u0", m0, st0, on0, upd0, err0, rdy0, per0, ini0, cmp0);
            cmp_dut("model_u1", m1, st1, on1, upd1, err1, rdy1, per1, ini1, cmp1);
        end
    end

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d required %0d", nm, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic clr();
        cfg_valid = 0; start_req = 0; stop_req = 0; evt_zero = 0; evt_max = 0;
    endtask

    task automatic cfg(input logic [15:0] p, input logic [15:0] i, input logic [15:0] c);
        cfg_valid = 1; cfg_period = p; cfg_init_carr = i; cfg_compare = c;
        tick(1);
        clr();
    endtask

    task automatic pulse_zero();
        evt_zero = 1; tick(1); clr();
    endtask

    initial begin
        m0 = mreset();
        m1 = mreset();
        reset = 1;
        tick(2);
        chk_en = 1;
        chk("rst_state", 16'(st0), 0);
        chk("rst_period", per0, 2000);
        chk("rst_init", ini0, 500);
        chk("rst_cmp", cmp0, 1000);
        chk("rst_onoff", 16'(on0), 0);
        chk("rst_ready", 16'(rdy0), 0);
        reset = 0;
        #1;
        chk("ready_after_rst", 16'(rdy0), 1);

        cfg(16'd1, 16'd0, 16'd0);
        chk("bad_cfg_err", 16'(err0), 1);
        chk("bad_cfg_period", per0, 2000);
        chk("bad_cfg_cmp", cmp0, 1000);
        chk("bad_cfg_upd", 16'(upd0), 0);
        tick(1);
        chk("bad_cfg_err_clr", 16'(err0), 0);

        cfg(16'd800, 16'd500, 16'd1000);
        chk("clamp_period", per0, 800);
        chk("clamp_cmp", cmp0, 800);
        chk("clamp_upd", 16'(upd0), 1);
        cfg(16'd300, 16'd400, 16'd100);
        chk("clamp_init", ini0, 300);
        chk("clamp_cmp2", cmp0, 100);

        start_req = 1; stop_req = 1; tick(1); clr();
        chk("start_stop_idle", 16'(st0), 0);

        reset = 1; tick(1); reset = 0;
        start_req = 1; tick(1); clr();
        chk("arm_state", 16'(st0), 1);
        tick(9);
        chk("arm_onoff", 16'(on0), 0);
        pulse_zero();
        chk("run_onoff", 16'(on0), 1);
        chk("run_state", 16'(st0), 2);
        chk("run_period", per0, 2000);
        chk("run_cmp", cmp0, 1000);

        cfg(16'd1500, 16'd600, 16'd667);
        chk("pend_state", 16'(st0), 3);
        chk("pend_period_hold", per0, 2000);
        evt_max = 1; tick(1); clr();
        chk("max_period_hold", per0, 2000);
        chk("max_init_hold", ini0, 500);
        chk("max_cmp_hold", cmp0, 1000);
        chk("max_no_upd", 16'(upd0), 0);
        chk("u1_max_applies", per1, 1500);
        pulse_zero();
        chk("zero_period", per0, 1500);
        chk("zero_init", ini0, 600);
        chk("zero_cmp", cmp0, 667);
        chk("zero_upd", 16'(upd0), 1);
        chk("zero_state", 16'(st0), 2);
        tick(1);
        chk("upd_one_cycle", 16'(upd0), 0);
        pulse_zero();
        chk("second_evt_no_upd", 16'(upd0), 0);

        cfg(16'd900, 16'd100, 16'd300);
        chk("pend2_state", 16'(st0), 3);
        stop_req = 1; evt_zero = 1; tick(1); clr();
        chk("stop_evt_state", 16'(st0), 4);
        chk("stop_evt_period", per0, 900);
        chk("stop_evt_init", ini0, 100);
        chk("stop_evt_cmp", cmp0, 300);
        chk("stop_evt_upd", 16'(upd0), 1);
        tick(3);
        chk("stop_onoff_hold", 16'(on0), 1);
        pulse_zero();
        chk("stop_onoff_fall", 16'(on0), 0);
        chk("stop_to_idle", 16'(st0), 0);

        start_req = 1; tick(1); clr();
        pulse_zero();
        cfg(16'd1200, 16'd10, 16'd20);
        chk("pend3_state", 16'(st0), 3);
        reset = 1; tick(1);
        chk("rst_pend_state", 16'(st0), 0);
        chk("rst_pend_onoff", 16'(on0), 0);
        chk("rst_pend_period", per0, 2000);
        chk("rst_pend_cmp", cmp0, 1000);
        reset = 0;
        pulse_zero();
        chk("rst_pend_no_upd", 16'(upd0), 0);
        chk("rst_pend_period2", per0, 2000);

        repeat (4000) begin
            reset       = ($urandom_range(0, 299) == 0);
            cfg_valid   = ($urandom_range(0, 3) == 0);
            cfg_period  = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 3)) : 16'($urandom_range(0, 3000));
            cfg_init_carr = 16'($urandom_range(0, 3000));
            cfg_compare = 16'($urandom_range(0, 3000));
            start_req   = ($urandom_range(0, 9) == 0);
            stop_req    = ($urandom_range(0, 19) == 0);
            evt_zero    = ($urandom_range(0, 7) == 0);
            evt_max     = ($urandom_range(0, 7) == 0);
            tick(1);
        end
        clr();
        reset = 0;
        tick(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
